// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider sequencer for the E stage: UDIV/SDIV, one quotient bit per cycle.
// Holds the front of the pipe via StallDivE and pulses DivDoneE for one cycle when results are ready.
module div_sequencer #(
  parameter int DATA_WIDTH       = 32,
  parameter int ALUCONTROL_WIDTH = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        StartE,
  input  logic [ALUCONTROL_WIDTH-1:0] ALUControlE,
  input  logic [DATA_WIDTH-1:0]       SrcAE,
  input  logic [DATA_WIDTH-1:0]       SrcBE,
  input  logic                        AbortE,
  output logic                        StallDivE,
  output logic                        DivDoneE,
  output logic [DATA_WIDTH-1:0]       QuotientE,
  output logic [DATA_WIDTH-1:0]       RemainderE,
  output logic                        DivByZeroE
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [ALUCONTROL_WIDTH-1:0] OpUdiv = ALUCONTROL_WIDTH'(6'b101110);
  localparam logic [ALUCONTROL_WIDTH-1:0] OpSdiv = ALUCONTROL_WIDTH'(6'b101111);
  localparam logic [5:0]                  LastStep = 6'(DATA_WIDTH - 1);

  logic [1:0]            stateR;
  logic [5:0]            countR;
  logic [DATA_WIDTH-1:0] quoR;
  logic [DATA_WIDTH-1:0] remR;
  logic [DATA_WIDTH-1:0] divR;
  logic                  quotNegR;
  logic                  remNegR;

  logic                  isDiv;
  logic                  signedOp;
  logic                  aNeg;
  logic                  bNeg;
  logic                  accept;
  logic [DATA_WIDTH-1:0] absA;
  logic [DATA_WIDTH-1:0] absB;
  logic [DATA_WIDTH:0]   trial;
  logic [DATA_WIDTH:0]   diff;
  logic                  fits;
  logic [DATA_WIDTH-1:0] remStep;
  logic [DATA_WIDTH-1:0] quoStep;

  always_comb begin
    isDiv     = (ALUControlE == OpUdiv) || (ALUControlE == OpSdiv);
    signedOp  = (ALUControlE == OpSdiv);
    aNeg      = signedOp & SrcAE[DATA_WIDTH-1];
    bNeg      = signedOp & SrcBE[DATA_WIDTH-1];
    absA      = aNeg ? -SrcAE : SrcAE;
    absB      = bNeg ? -SrcBE : SrcBE;
    accept    = (stateR == IDLE) & StartE & isDiv & ~AbortE;
    StallDivE = accept | (stateR == BUSY);
    DivDoneE  = (stateR == DONE);
  end

  // Quotient register doubles as the dividend shifter: each step pulls its MSB into the
  // partial remainder and shifts the new quotient bit in at the bottom.
  always_comb begin
    trial   = {remR, quoR[DATA_WIDTH-1]};
    diff    = trial - {1'b0, divR};
    fits    = ~diff[DATA_WIDTH];
    remStep = fits ? diff[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
    quoStep = {quoR[DATA_WIDTH-2:0], fits};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateR     <= IDLE;
      countR     <= '0;
      quoR       <= '0;
      remR       <= '0;
      divR       <= '0;
      quotNegR   <= 1'b0;
      remNegR    <= 1'b0;
      QuotientE  <= '0;
      RemainderE <= '0;
      DivByZeroE <= 1'b0;
    end else begin
      case (stateR)
        IDLE: begin
          if (accept) begin
            quoR     <= absA;
            remR     <= '0;
            divR     <= absB;
            quotNegR <= aNeg ^ bNeg;
            remNegR  <= aNeg;
            countR   <= '0;
            if (SrcBE == '0) begin
              stateR     <= DONE;
              QuotientE  <= '0;
              RemainderE <= SrcAE;
              DivByZeroE <= 1'b1;
            end else begin
              stateR <= BUSY;
            end
          end
        end
        BUSY: begin
          if (AbortE) begin
            stateR <= IDLE;
          end else begin
            quoR   <= quoStep;
            remR   <= remStep;
            countR <= countR + 6'd1;
            if (countR == LastStep) begin
              stateR     <= DONE;
              QuotientE  <= quotNegR ? -quoStep : quoStep;
              RemainderE <= remNegR ? -remStep : remStep;
              DivByZeroE <= 1'b0;
            end
          end
        end
        DONE:    stateR <= IDLE;
        default: stateR <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed corner cases plus randomized UDIV/SDIV
// compared against an arithmetic reference model.
module tb_div_sequencer;

  localparam int W = 32;
  localparam logic [5:0] UDIV = 6'b101110;
  localparam logic [5:0] SDIV = 6'b101111;

  logic         clk = 1'b0;
  logic         reset;
  logic         StartE;
  logic [5:0]   ALUControlE;
  logic [W-1:0] SrcAE;
  logic [W-1:0] SrcBE;
  logic         AbortE;
  logic         StallDivE;
  logic         DivDoneE;
  logic [W-1:0] QuotientE;
  logic [W-1:0] RemainderE;
  logic         DivByZeroE;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] lastQ = '0;
  logic [W-1:0] lastR = '0;
  logic         lastZ = 1'b0;

  div_sequencer #(.DATA_WIDTH(W), .ALUCONTROL_WIDTH(6)) dut (
    .clk(clk), .reset(reset), .StartE(StartE), .ALUControlE(ALUControlE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .AbortE(AbortE), .StallDivE(StallDivE),
    .DivDoneE(DivDoneE), .QuotientE(QuotientE), .RemainderE(RemainderE),
    .DivByZeroE(DivByZeroE)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: C-style truncating division; remainder carries the dividend's sign.
  function automatic void model(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sa, sb;
    if (b == '0) begin
      q = '0; r = a; z = 1'b1;
    end else if (op == SDIV) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = W'(sa / sb);
      r = W'(sa % sb);
      z = 1'b0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endfunction

  task automatic startOp(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    checkVal("doneSinglePulse", W'(DivDoneE), 0);
    StartE = 1'b1; ALUControlE = op; SrcAE = a; SrcBE = b; AbortE = 1'b0;
    #1 checkVal("stallAccept", W'(StallDivE), 1);
    @(negedge clk);
    StartE = 1'b0; SrcAE = $urandom; SrcBE = $urandom;
    #1;
  endtask

  task automatic runDiv(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eq, er;
    logic ez;
    int cyc, stalls;
    model(op, a, b, eq, er, ez);
    startOp(op, a, b);
    cyc = 1; stalls = 1;
    while (!DivDoneE && cyc < 100) begin
      if (StallDivE) stalls++;
      @(negedge clk); #1;
      cyc++;
    end
    checkVal("latency", W'(cyc), ez ? 1 : W + 1);
    checkVal("stallCycles", W'(stalls), ez ? 1 : W + 1);
    checkVal("stallInDone", W'(StallDivE), 0);
    checkVal("quotient", QuotientE, eq);
    checkVal("remainder", RemainderE, er);
    checkVal("divByZero", W'(DivByZeroE), W'(ez));
    lastQ = eq; lastR = er; lastZ = ez;
  endtask

  task automatic watchNoDone(input string tag, input int cycles);
    int pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk); #1;
      if (DivDoneE) pulses++;
    end
    checkVal(tag, W'(pulses), 0);
  endtask

  // Abort while the step counter reads `at`.
  task automatic runAbort(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int at);
    startOp(op, a, b);
    for (int i = 0; i < at; i++) begin
      @(negedge clk); #1;
    end
    AbortE = 1'b1;
    #1 checkVal("stallAtAbort", W'(StallDivE), 1);
    @(negedge clk);
    AbortE = 1'b0;
    #1;
    checkVal("stallAfterAbort", W'(StallDivE), 0);
    checkVal("doneAfterAbort", W'(DivDoneE), 0);
    checkVal("abortKeepsQ", QuotientE, lastQ);
    checkVal("abortKeepsR", RemainderE, lastR);
    checkVal("abortKeepsZ", W'(DivByZeroE), W'(lastZ));
    watchNoDone("noDoneAfterAbort", 40);
  endtask

  task automatic runReset(input int at);
    startOp(UDIV, 32'd1000, 32'd3);
    for (int i = 0; i < at; i++) begin
      @(negedge clk); #1;
    end
    reset = 1'b1;
    #1;
    checkVal("resetStall", W'(StallDivE), 0);
    checkVal("resetQ", QuotientE, 0);
    checkVal("resetR", RemainderE, 0);
    @(negedge clk);
    reset = 1'b0;
    lastQ = '0; lastR = '0; lastZ = 1'b0;
    watchNoDone("noDoneAfterReset", 40);
  endtask

  initial begin
    logic [5:0] op;
    logic [W-1:0] a, b;
    reset = 1'b1; StartE = 1'b0; ALUControlE = '0; SrcAE = '0; SrcBE = '0; AbortE = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkVal("rstQ", QuotientE, 0);
    checkVal("rstR", RemainderE, 0);
    checkVal("rstDone", W'(DivDoneE), 0);
    checkVal("rstDbz", W'(DivByZeroE), 0);
    checkVal("rstStall", W'(StallDivE), 0);
    @(negedge clk);
    reset = 1'b0;

    runDiv(UDIV, 32'd100, 32'd7);
    runDiv(SDIV, 32'hFFFFFF9C, 32'd7);
    runDiv(SDIV, 32'd100, 32'hFFFFFFF9);
    runDiv(UDIV, 32'd5, 32'd0);
    runDiv(SDIV, 32'h80000000, 32'hFFFFFFFF);
    runDiv(UDIV, 32'hFFFFFFFF, 32'd1);
    runDiv(SDIV, 32'hFFFFFFF0, 32'd0);

    // Non-divide opcodes and an aborted start must never be accepted.
    @(negedge clk);
    StartE = 1'b1; ALUControlE = 6'b000010; SrcAE = 32'd9; SrcBE = 32'd3;
    #1 checkVal("otherOpNoStall", W'(StallDivE), 0);
    AbortE = 1'b1; ALUControlE = UDIV;
    #1 checkVal("abortBlocksAccept", W'(StallDivE), 0);
    watchNoDone("noDoneIgnored", 3);
    StartE = 1'b0; AbortE = 1'b0;

    runAbort(UDIV, 32'd12345, 32'd17, 10);
    runAbort(SDIV, 32'hFFFF0000, 32'd5, W - 1);
    runReset(20);
    runDiv(UDIV, 32'd9, 32'd3);
    runDiv(UDIV, 32'd77, 32'd10);

    for (int n = 0; n < 30; n++) begin
      op = $urandom_range(1) ? SDIV : UDIV;
      a  = $urandom;
      case ($urandom_range(7))
        0:       b = '0;
        1, 2:    b = W'($urandom_range(15));
        3:       b = -W'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      runDiv(op, a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
